mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts the EX/MEM load/store control into a req/ack transaction on the data RAM port, with byte enables and store-data lane placement.
- Sign- or zero-extends load data into MEM_rdo for the MEM/WB register.
- Holds the pipeline via mem_stall while a transaction is outstanding.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without dmem_ack before bus error (1..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- MEM_valid  input  1  EX/MEM slot holds a real instruction
- MEM_dram_re  input  1  load
- MEM_dram_we  input  1  store
- MEM_funct3  input  3  access size/sign (RISC-V funct3)
- MEM_alu_c  input  32  byte address
- MEM_rD2  input  32  store data (low bits significant)
- MEM_rdo  output  32  extended load data, registered
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB must load a bubble
- mem_misalign  output  1  one-cycle pulse: misaligned or illegal access
- mem_buserr  output  1  one-cycle pulse: ack timeout
- dmem_req  output  1  request, registered
- dmem_we  output  1  write strobe, valid with req
- dmem_addr  output  32  word address {MEM_alu_c[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-placed store data
- dmem_rdata  input  32  read data, valid with ack
- dmem_ack  input  1  one-cycle completion

Behaviour:
- Reset (async, rst high): state=IDLE; dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, MEM_rdo, mem_misalign, mem_buserr, timeout counter all 0. mem_stall is forced 0 while rst is high.
- A cycle is an access when MEM_valid & (MEM_dram_re | MEM_dram_we).
- If both re and we are set, the access is a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
- States:
  - IDLE:
    - Access that is legal and aligned: mem_stall=1 combinationally in the same cycle. Next edge: register req=1, we, addr, be, wdata; clear the counter; go to WAIT.
    - Access that is illegal or misaligned: no request, no stall. Next edge: pulse mem_misalign for one cycle and load MEM_rdo=0. The instruction proceeds.
    - No access: stay in IDLE. MEM_rdo holds its value.
  - WAIT:
    - mem_stall=1 and dmem_req stays high with all outputs stable.
    - dmem_ack=1: next edge drops req; for a load, loads MEM_rdo from extended dmem_rdata; go to DONE.
    - No ack: the counter increments. When count==TIMEOUT-1 with no ack, next edge drops req, loads MEM_rdo=0, pulses mem_buserr, and goes to DONE.
  - DONE:
    - mem_stall=0 for exactly this cycle, so the pipeline advances and MEM/WB captures MEM_rdo.
    - Next edge goes unconditionally to IDLE. The new EX/MEM contents are evaluated only in IDLE, so there is no double issue.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{rD2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011; wdata={2{rD2[15:0]}}.
  - SW: be=4'b1111; wdata=rD2.
  - Loads: be=4'b1111, we=0.
- Load extract: select the byte by addr[1:0] or the halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- dmem_ack outside WAIT is ignored.
- Reset mid-transaction: req drops immediately (async) and state returns to IDLE. The RAM must tolerate the withdrawn request.
- Minimum access latency: 3 cycles (IDLE detect, WAIT with ack in its first cycle, DONE).

Test Plan:
- LW addr 0x100, RAM acks 2 cycles after req with 0xDEADBEEF -> req high 2 cycles, be=1111, stall high 3 cycles, MEM_rdo=0xDEADBEEF in DONE.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80112233 -> MEM_rdo=0xFFFFFF80 and 0x00000080 respectively.
- SH addr 0x202, rD2=0x0000ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1. SB addr 0x201, rD2=0x55 -> be=0010.
- LW addr 0x102 -> no req, no stall, mem_misalign pulse one cycle, MEM_rdo=0. funct3=011 store -> same response.
- TIMEOUT=16, RAM never acks -> req high exactly 16 cycles, then mem_buserr pulse, MEM_rdo=0, one DONE cycle with stall=0.
- rst asserted in the 2nd WAIT cycle, then ack pulse after release -> req and stall drop asynchronously, state IDLE, stray ack ignored, next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Turns EX/MEM load/store control into a req/ack RAM transaction.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic        MEM_dram_re,
    input  logic        MEM_dram_we,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_alu_c,
    input  logic [31:0] MEM_rD2,
    output logic [31:0] MEM_rdo,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdo;
    logic             r_misalign;
    logic             r_buserr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;

    logic             w_access;
    logic             w_store;
    logic             w_legal;
    logic             w_misal;
    logic             w_go;
    logic             w_bad;
    logic             w_tmo;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    assign w_access = MEM_valid & (MEM_dram_re | MEM_dram_we);
    // A cycle with both re and we set is treated as a store.
    assign w_store  = MEM_dram_we;
    assign w_misal  = ((MEM_funct3[1:0] == 2'b01) & MEM_alu_c[0])
                    | ((MEM_funct3[1:0] == 2'b10) & (|MEM_alu_c[1:0]));
    assign w_go     = w_access & w_legal & ~w_misal;
    assign w_bad    = w_access & ~(w_legal & ~w_misal);
    assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Classify funct3 as a legal load or store size.
    always_comb begin
        w_legal = 1'b0;
        case (MEM_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~w_store;
            default:                w_legal = 1'b0;
        endcase
    end

    // Byte enables and lane replication of store data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_rD2;
        if (w_store) begin
            case (MEM_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << MEM_alu_c[1:0];
                    w_wdata = {4{MEM_rD2[7:0]}};
                end
                2'b01: begin
                    w_be    = MEM_alu_c[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{MEM_rD2[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = MEM_rD2;
                end
            endcase
        end
    end

    // Pick the addressed byte/halfword from read data and extend it.
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state; DONE always returns to IDLE so nothing issues twice.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_WAIT;
            S_WAIT: if (dmem_ack || w_tmo) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request registers, load result, timeout counter and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_rdo      <= '0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_cnt      <= '0;
            r_f3       <= '0;
            r_off      <= '0;
        end else begin
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= {MEM_alu_c[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_f3    <= MEM_funct3;
                        r_off   <= MEM_alu_c[1:0];
                    end else if (w_bad) begin
                        r_misalign <= 1'b1;
                        r_rdo      <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdo <= w_ext;
                    end else if (w_tmo) begin
                        r_req    <= 1'b0;
                        r_rdo    <= '0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall is withheld in DONE so MEM/WB captures the result.
    assign mem_stall = ~rst & (((r_state == S_IDLE) & w_go)
                             | (r_state == S_WAIT));

    assign MEM_rdo      = r_rdo;
    assign mem_misalign = r_misalign;
    assign mem_buserr   = r_buserr;
    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_be      = r_be;
    assign dmem_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Drives the RAM side by hand and checks hand-computed results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid;
    logic        MEM_dram_re;
    logic        MEM_dram_we;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_c;
    logic [31:0] MEM_rD2;
    logic [31:0] MEM_rdo;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_buserr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int n_vec = 0;
    int n_err = 0;

    int          reqc;
    int          stc;
    logic [3:0]  be1;
    logic [31:0] addr1;
    logic [31:0] wd1;
    logic        we1;

    mem_access_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_valid    (MEM_valid),
        .MEM_dram_re  (MEM_dram_re),
        .MEM_dram_we  (MEM_dram_we),
        .MEM_funct3   (MEM_funct3),
        .MEM_alu_c    (MEM_alu_c),
        .MEM_rD2      (MEM_rD2),
        .MEM_rdo      (MEM_rdo),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .mem_buserr   (mem_buserr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        MEM_valid   = 1'b0;
        MEM_dram_re = 1'b0;
        MEM_dram_we = 1'b0;
    endtask

    // Present one access and play the RAM; ack_at=0 means never ack.
    task automatic run_acc(input logic re, input logic we,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rd);
        MEM_valid   = 1'b1;
        MEM_dram_re = re;
        MEM_dram_we = we;
        MEM_funct3  = f3;
        MEM_alu_c   = a;
        MEM_rD2     = wd;
        reqc = 0;
        stc  = 0;
        be1  = '0;
        addr1 = '0;
        wd1  = '0;
        we1  = 1'b0;
        #1;
        if (mem_stall) stc++;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (!dmem_req) break;
            reqc++;
            if (mem_stall) stc++;
            if (c == 1) begin
                be1   = dmem_be;
                addr1 = dmem_addr;
                wd1   = dmem_wdata;
                we1   = dmem_we;
            end
            if (c == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h0BAD_0BAD;
            end
        end
        dmem_ack = 1'b0;
        idle_in();
    endtask

    initial begin
        rst         = 1'b1;
        idle_in();
        MEM_funct3  = 3'b010;
        MEM_alu_c   = 32'h100;
        MEM_rD2     = '0;
        dmem_rdata  = '0;
        dmem_ack    = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_rdo", MEM_rdo, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        MEM_valid   = 1'b1;
        MEM_dram_re = 1'b1;
        #1;
        chk("rst_stall_forced", {31'd0, mem_stall}, 32'd0);
        idle_in();
        tick();
        rst = 1'b0;
        tick();

        // LW, ack in second WAIT cycle
        run_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        chk("lw_reqc", reqc, 32'd2);
        chk("lw_stallc", stc, 32'd3);
        chk("lw_be", {28'd0, be1}, 32'hF);
        chk("lw_addr", addr1, 32'h100);
        chk("lw_done_stall", {31'd0, mem_stall}, 32'd0);
        chk("lw_rdo", MEM_rdo, 32'hDEADBEEF);
        tick();

        run_acc(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lb_rdo", MEM_rdo, 32'hFFFFFF80);
        tick();
        run_acc(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lbu_rdo", MEM_rdo, 32'h00000080);
        tick();
        run_acc(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233);
        chk("lh_rdo", MEM_rdo, 32'hFFFF8011);
        tick();
        run_acc(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h80112233);
        chk("lhu_rdo", MEM_rdo, 32'h00002233);
        tick();

        // SH to upper half, both re and we set -> store
        run_acc(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);
        chk("sh_addr", addr1, 32'h200);
        chk("sh_be", {28'd0, be1}, 32'hC);
        chk("sh_wdata", wd1, 32'hABCDABCD);
        chk("sh_we", {31'd0, we1}, 32'd1);
        chk("sh_rdo_held", MEM_rdo, 32'h00002233);
        tick();
        run_acc(1'b0, 1'b1, 3'b000, 32'h201, 32'h00000055, 1, 32'h0);
        chk("sb_be", {28'd0, be1}, 32'h2);
        chk("sb_wdata", wd1, 32'h55555555);
        tick();

        // Misaligned LW
        MEM_valid   = 1'b1;
        MEM_dram_re = 1'b1;
        MEM_funct3  = 3'b010;
        MEM_alu_c   = 32'h102;
        #1;
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        idle_in();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_pulse", {31'd0, mem_misalign}, 32'd1);
        chk("mis_rdo", MEM_rdo, 32'd0);
        tick();
        chk("mis_pulse_end", {31'd0, mem_misalign}, 32'd0);

        // Illegal store funct3=011
        run_acc(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h11110000);
        tick();
        MEM_valid   = 1'b1;
        MEM_dram_we = 1'b1;
        MEM_funct3  = 3'b011;
        MEM_alu_c   = 32'h100;
        #1;
        chk("ill_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        idle_in();
        chk("ill_req", {31'd0, dmem_req}, 32'd0);
        chk("ill_pulse", {31'd0, mem_misalign}, 32'd1);
        chk("ill_rdo", MEM_rdo, 32'd0);
        tick();

        // Timeout: no ack ever
        run_acc(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        chk("to_reqc", reqc, 32'd16);
        chk("to_buserr", {31'd0, mem_buserr}, 32'd1);
        chk("to_rdo", MEM_rdo, 32'd0);
        chk("to_done_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("to_buserr_end", {31'd0, mem_buserr}, 32'd0);

        // Reset in second WAIT cycle, then a stray ack
        MEM_valid   = 1'b1;
        MEM_dram_re = 1'b1;
        MEM_funct3  = 3'b010;
        MEM_alu_c   = 32'h100;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_req", {31'd0, dmem_req}, 32'd0);
        chk("mrst_stall", {31'd0, mem_stall}, 32'd0);
        idle_in();
        tick();
        rst = 1'b0;
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack   = 1'b0;
        chk("stray_req", {31'd0, dmem_req}, 32'd0);
        chk("stray_stall", {31'd0, mem_stall}, 32'd0);
        chk("stray_rdo", MEM_rdo, 32'd0);
        tick();
        run_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h12345678);
        chk("post_reqc", reqc, 32'd1);
        chk("post_stallc", stc, 32'd2);
        chk("post_rdo", MEM_rdo, 32'h12345678);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
